// File: rtl/etap_ir_ctrl.sv
// EJTAG TAP instruction register: capture/shift stage, update stage, registered decode, sticky boot flag.
// Latency: ir/sel/ejtag_boot one cycle after the update edge; ir_tdo combinational from sr[0].
// Backpressure: none, the strobes are TAP states. The boot flag is built only with ETAP_IR_BOOT_EN.
module etap_ir_ctrl #(
  parameter int IR_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            tlr,
  input  logic            capture_ir,
  input  logic            shift_ir,
  input  logic            update_ir,
  input  logic            tdi,
  input  logic [IR_W-3:0] status,
  output logic            ir_tdo,
  output logic [IR_W-1:0] ir,
  output logic [3:0]      sel,
  output logic            sel_upd,
  output logic            ejtag_boot
);

  localparam logic [IR_W-1:0] OP_IDCODE     = IR_W'(8'h01);
  localparam logic [IR_W-1:0] OP_SAMPLE     = IR_W'(8'h02);
  localparam logic [IR_W-1:0] OP_IMPCODE    = IR_W'(8'h03);
  localparam logic [IR_W-1:0] OP_ADDRESS    = IR_W'(8'h08);
  localparam logic [IR_W-1:0] OP_DATA       = IR_W'(8'h09);
  localparam logic [IR_W-1:0] OP_CONTROL    = IR_W'(8'h0A);
  localparam logic [IR_W-1:0] OP_ALL        = IR_W'(8'h0B);
  localparam logic [IR_W-1:0] OP_EJTAGBOOT  = IR_W'(8'h0C);
  localparam logic [IR_W-1:0] OP_NORMALBOOT = IR_W'(8'h0D);
  localparam logic [IR_W-1:0] OP_FASTDATA   = IR_W'(8'h0E);
  localparam logic [IR_W-1:0] OP_BYPASS     = {IR_W{1'b1}};
  localparam logic [IR_W-1:0] SR_RESET      = IR_W'(1);

  logic [IR_W-1:0] sr;
  logic            tlr_q;

  // Exact match on every bit; anything unlisted selects the bypass register.
  function automatic logic [3:0] decode(input logic [IR_W-1:0] op);
    logic [3:0] s;
    s = 4'd6;
    case (op)
      OP_IDCODE:     s = 4'd0;
      OP_IMPCODE:    s = 4'd1;
      OP_ADDRESS:    s = 4'd2;
      OP_DATA:       s = 4'd3;
      OP_CONTROL:    s = 4'd4;
      OP_BYPASS:     s = 4'd6;
      OP_SAMPLE:     s = 4'd7;
      OP_ALL:        s = 4'd8;
      OP_FASTDATA:   s = 4'd10;
`ifdef ETAP_IR_BOOT_EN
      OP_EJTAGBOOT:  s = 4'd5;
      OP_NORMALBOOT: s = 4'd9;
`endif
      default:       s = 4'd6;
    endcase
    return s;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      sr      <= SR_RESET;
      ir      <= OP_IDCODE;
      sel     <= 4'd0;
      sel_upd <= 1'b0;
      tlr_q   <= 1'b0;
    end else begin
      tlr_q   <= tlr;
      sel_upd <= 1'b0;
      if (tlr) begin
        sr      <= SR_RESET;
        ir      <= OP_IDCODE;
        sel     <= 4'd0;
        sel_upd <= ~tlr_q;
      end else if (update_ir) begin
        ir      <= sr;
        sel     <= decode(sr);
        sel_upd <= 1'b1;
      end else if (capture_ir) begin
        sr <= {status, 2'b01};
      end else if (shift_ir) begin
        sr <= {tdi, sr[IR_W-1:1]};
      end
    end
  end

  assign ir_tdo = sr[0];

`ifdef ETAP_IR_BOOT_EN
  logic boot_q;

  // Survives TLR on purpose: only a real reset or NORMALBOOT drops the request.
  always_ff @(posedge clk) begin
    if (rst) begin
      boot_q <= 1'b0;
    end else if (!tlr && update_ir) begin
      if (sr == OP_EJTAGBOOT) begin
        boot_q <= 1'b1;
      end else if (sr == OP_NORMALBOOT) begin
        boot_q <= 1'b0;
      end
    end
  end

  assign ejtag_boot = boot_q;
`else
  assign ejtag_boot = 1'b0;
`endif

endmodule

// File: tb/tb_etap_ir_ctrl.sv
// Bench for etap_ir_ctrl: two widths (5 and 8) driven by one strobe stream, scoreboarded IR loads.
module tb_etap_ir_ctrl;

`ifdef ETAP_IR_BOOT_EN
  localparam bit BOOT = 1'b1;
`else
  localparam bit BOOT = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, tlr = 1'b0, cap = 1'b0, sh = 1'b0, upd = 1'b0, tdi = 1'b0;
  logic [2:0] st5 = '0;
  logic [5:0] st8 = '0;

  logic       tdo5, su5, eb5;
  logic [4:0] ir5;
  logic [3:0] sel5;
  logic       tdo8, su8, eb8;
  logic [7:0] ir8;
  logic [3:0] sel8;

  etap_ir_ctrl #(.IR_W(5)) dut5 (
    .clk(clk), .rst(rst), .tlr(tlr), .capture_ir(cap), .shift_ir(sh), .update_ir(upd),
    .tdi(tdi), .status(st5), .ir_tdo(tdo5), .ir(ir5), .sel(sel5), .sel_upd(su5), .ejtag_boot(eb5)
  );

  etap_ir_ctrl #(.IR_W(8)) dut8 (
    .clk(clk), .rst(rst), .tlr(tlr), .capture_ir(cap), .shift_ir(sh), .update_ir(upd),
    .tdi(tdi), .status(st8), .ir_tdo(tdo8), .ir(ir8), .sel(sel8), .sel_upd(su8), .ejtag_boot(eb8)
  );

  typedef struct {
    int ir;
    int sel;
    bit boot;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int nchk = 0;
  int npass = 0;

  // Reference state: plain integers per instance (0 -> width 5, 1 -> width 8).
  int m_sr[2];
  int m_ir[2];
  bit m_boot[2];
  bit m_tlrp[2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic int dec(input int op, input int w);
    if (op == (1 << w) - 1) return 6;
    case (op)
      1:  return 0;
      2:  return 7;
      3:  return 1;
      8:  return 2;
      9:  return 3;
      10: return 4;
      11: return 8;
      12: return BOOT ? 5 : 6;
      13: return BOOT ? 9 : 6;
      14: return 10;
      default: return 6;
    endcase
  endfunction

  task automatic push(input int k, input int irv, input int s, input bit b);
    exp_t e;
    e.ir = irv; e.sel = s; e.boot = b;
    if (k == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  // Applies one clock edge's worth of the rules, highest-priority strobe first.
  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      int w;
      int stv;
      w   = (k == 0) ? 5 : 8;
      stv = (k == 0) ? int'(st5) : int'(st8);
      if (rst) begin
        m_sr[k] = 1; m_ir[k] = 1; m_boot[k] = 1'b0; m_tlrp[k] = 1'b0;
      end else begin
        if (tlr) begin
          m_sr[k] = 1;
          m_ir[k] = 1;
          if (!m_tlrp[k]) push(k, 1, 0, m_boot[k]);
        end else if (upd) begin
          m_ir[k] = m_sr[k];
          if (BOOT && m_sr[k] == 12) m_boot[k] = 1'b1;
          if (BOOT && m_sr[k] == 13) m_boot[k] = 1'b0;
          push(k, m_sr[k], dec(m_sr[k], w), m_boot[k]);
        end else if (cap) begin
          m_sr[k] = (stv << 2) | 1;
        end else if (sh) begin
          m_sr[k] = (m_sr[k] >> 1) | (int'(tdi) << (w - 1));
        end
        m_tlrp[k] = tlr;
      end
    end
  endtask

  task automatic cyc(input bit r, input bit t, input bit c, input bit s, input bit u, input bit d);
    rst = r; tlr = t; cap = c; sh = s; upd = u; tdi = d;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("tdo_w5", tdo5, m_sr[0] & 1);
    chk("tdo_w8", tdo8, m_sr[1] & 1);
    chk("boot_w5", eb5, m_boot[0]);
    chk("boot_w8", eb8, m_boot[1]);
    chk("ir_w5", ir5, m_ir[0]);
  endtask

  task automatic load(input int v, input int n);
    cyc(0, 0, 1, 0, 0, 0);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 1, 0, bit'((v >> i) & 1));
    cyc(0, 0, 0, 0, 1, 0);
  endtask

  task automatic mon(input int k, input logic su, input logic [31:0] irv, input logic [3:0] s,
                     input logic b);
    exp_t e;
    int sz;
    sz = (k == 0) ? q0.size() : q1.size();
    if (su === 1'b1) begin
      if (sz == 0) begin
        chk($sformatf("sel_upd_spurious_%0d", k), su, 0);
      end else begin
        e = (k == 0) ? q0.pop_front() : q1.pop_front();
        chk($sformatf("upd_ir_%0d", k), irv, e.ir);
        chk($sformatf("upd_sel_%0d", k), s, e.sel);
        chk($sformatf("upd_boot_%0d", k), b, e.boot);
      end
    end else if (sz != 0) begin
      chk($sformatf("sel_upd_missing_%0d", k), su, 1);
      if (k == 0) q0.delete();
      else q1.delete();
    end
  endtask

  always @(negedge clk) begin
    mon(0, su5, 32'(ir5), sel5, eb5);
    mon(1, su8, 32'(ir8), sel8, eb8);
  end

  initial begin
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    chk("rst_ir", ir5, 32'h01);
    chk("rst_sel", sel5, 0);
    chk("rst_tdo", tdo5, 1);
    chk("rst_boot", eb5, 0);
    chk("rst_sel_upd", su5, 0);

    st5 = 3'b101;
    load(32'h0A, 5);
    chk("ir_0a", ir5, 32'h0A);
    chk("sel_0a", sel5, 4);

    load(32'h05, 5);
    chk("ir_05", ir5, 32'h05);
    chk("sel_05", sel5, 6);
    load(32'h1F, 5);
    chk("sel_1f", sel5, 6);

    load(32'h0C, 5);
    if (BOOT) begin
      chk("boot_set", eb5, 1);
      chk("sel_ejtagboot", sel5, 5);
      repeat (3) cyc(0, 1, 0, 0, 0, 0);
      chk("tlr_ir", ir5, 32'h01);
      chk("tlr_keeps_boot", eb5, 1);
      cyc(0, 0, 0, 0, 0, 0);
      load(32'h0D, 5);
      chk("boot_clear", eb5, 0);
      chk("sel_normalboot", sel5, 9);
    end else begin
      chk("sel_0c_nb", sel5, 6);
      chk("boot_tied", eb5, 0);
      repeat (3) cyc(0, 1, 0, 0, 0, 0);
      chk("tlr_ir", ir5, 32'h01);
      cyc(0, 0, 0, 0, 0, 0);
    end

    // update beats shift; sr must stay as captured (0b10101)
    st5 = 3'b101;
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 1, 0);
    chk("prio_upd_ir", ir5, 32'h15);
    chk("prio_upd_tdo", tdo5, 1);
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 1, 0, 0, 1, 0);
    chk("prio_tlr_ir", ir5, 32'h01);
    cyc(0, 0, 0, 0, 0, 0);

    load(32'hFF, 8);
    chk("w8_sel_ff", sel8, 6);
    load(32'h09, 8);
    chk("w8_ir_09", ir8, 32'h09);
    chk("w8_sel_09", sel8, 3);
    load(32'h89, 8);
    chk("w8_sel_89", sel8, 6);

    // back-to-back updates each produce a load
    load(32'h03, 5);
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 0);

    // reset in the middle of a shift
    load(32'h0C, 5);
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    cyc(1, 0, 0, 1, 0, 1);
    chk("midrst_ir", ir5, 32'h01);
    chk("midrst_boot", eb5, 0);
    chk("midrst_tdo", tdo5, 1);
    chk("midrst_sel_upd", su5, 0);

    for (int i = 0; i < 600; i++) begin
      st5 = 3'($urandom);
      st8 = 6'($urandom);
      cyc($urandom_range(0, 199) == 0, $urandom_range(0, 24) == 0,
          $urandom_range(0, 9) == 0, $urandom_range(0, 2) != 0,
          $urandom_range(0, 7) == 0, 1'($urandom));
    end
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
